// File: rtl/entropy_src_ht_window_ctrl.sv
// Health-test window controller: counts raw-entropy symbols into windows, gathers
// per-test fail strobes and reports done/fail/alert to the entropy_src main SM.
module entropy_src_ht_window_ctrl #(
    parameter int unsigned RngBusWidth = 4,
    parameter int unsigned NumTests    = 5,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] window_size_i,
    input  logic                symbol_vld_i,
    input  logic [NumTests-1:0] test_fail_i,
    input  logic [CntWidth-1:0] alert_threshold_i,
    input  logic                rst_alert_cntr_i,
    output logic                ht_done_pulse_o,
    output logic                ht_fail_pulse_o,
    output logic                alert_thresh_fail_o,
    output logic [NumTests-1:0] fail_tests_o,
    output logic [CntWidth-1:0] alert_cnt_o,
    output logic [CntWidth-1:0] total_fail_cnt_o,
    output logic [CntWidth-1:0] window_bits_o,
    output logic                cfg_err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StEval = 2'd2;

    localparam logic [CntWidth-1:0] SymBits = CntWidth'(RngBusWidth);
    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    logic [1:0]          state_q, state_d;
    logic                enable_q;
    logic [CntWidth-1:0] win_size_q, win_size_d;
    logic [CntWidth-1:0] window_bits_q, window_bits_d;
    logic [NumTests-1:0] sticky_q, sticky_d;
    logic [NumTests-1:0] pending_q, pending_d;
    logic [NumTests-1:0] fail_tests_q, fail_tests_d;
    logic [CntWidth-1:0] alert_cnt_q, alert_cnt_d;
    logic [CntWidth-1:0] total_fail_q, total_fail_d;
    logic                cfg_err_q, cfg_err_d;

    logic                done;
    logic                fail;
    logic                last_sym;
    logic                size_ok;
    logic [NumTests-1:0] eval_fails;
    logic [CntWidth-1:0] alert_cnt_next;

    // Window evaluation terms; late fails in the Eval cycle still belong to the completed window
    always_comb begin
        done           = (state_q == StEval) && enable_i;
        eval_fails     = pending_q | test_fail_i;
        fail           = done && (|eval_fails);
        alert_cnt_next = (fail && (alert_cnt_q != CntMax)) ? alert_cnt_q + CntOne : alert_cnt_q;
        size_ok        = (window_size_i != '0) && ((window_size_i % SymBits) == '0);
        last_sym       = symbol_vld_i && ((window_bits_q + SymBits) == win_size_q);
    end

    always_comb begin
        state_d       = state_q;
        win_size_d    = win_size_q;
        window_bits_d = window_bits_q;
        sticky_d      = sticky_q;
        pending_d     = pending_q;
        fail_tests_d  = fail_tests_q;
        cfg_err_d     = cfg_err_q;
        alert_cnt_d   = rst_alert_cntr_i ? '0 : alert_cnt_next;
        total_fail_d  = (fail && (total_fail_q != CntMax)) ? total_fail_q + CntOne : total_fail_q;

        if (!enable_i) begin
            state_d       = StIdle;
            window_bits_d = '0;
            sticky_d      = '0;
            pending_d     = '0;
            alert_cnt_d   = '0;
            cfg_err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!enable_q) begin
                        win_size_d = window_size_i;
                        if (size_ok) begin
                            state_d = StRun;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (last_sym) begin
                        window_bits_d = '0;
                        pending_d     = sticky_q | test_fail_i;
                        sticky_d      = '0;
                        state_d       = StEval;
                    end else begin
                        sticky_d = sticky_q | test_fail_i;
                        if (symbol_vld_i) begin
                            window_bits_d = window_bits_q + SymBits;
                        end
                    end
                end
                StEval: begin
                    fail_tests_d = eval_fails;
                    pending_d    = '0;
                    state_d      = StRun;
                    // A symbol here opens the next window (and may close it for tiny windows)
                    if (last_sym) begin
                        window_bits_d = '0;
                        pending_d     = sticky_q;
                        sticky_d      = '0;
                        state_d       = StEval;
                    end else if (symbol_vld_i) begin
                        window_bits_d = window_bits_q + SymBits;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            enable_q      <= 1'b0;
            win_size_q    <= '0;
            window_bits_q <= '0;
            sticky_q      <= '0;
            pending_q     <= '0;
            fail_tests_q  <= '0;
            alert_cnt_q   <= '0;
            total_fail_q  <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_i;
            win_size_q    <= win_size_d;
            window_bits_q <= window_bits_d;
            sticky_q      <= sticky_d;
            pending_q     <= pending_d;
            fail_tests_q  <= fail_tests_d;
            alert_cnt_q   <= alert_cnt_d;
            total_fail_q  <= total_fail_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign ht_done_pulse_o     = done;
    assign ht_fail_pulse_o     = fail;
    assign alert_thresh_fail_o = done && (alert_threshold_i != '0) &&
                                 (alert_cnt_next >= alert_threshold_i);
    assign fail_tests_o        = fail_tests_q;
    assign alert_cnt_o         = alert_cnt_q;
    assign total_fail_cnt_o    = total_fail_q;
    assign window_bits_o       = window_bits_q;
    assign cfg_err_o           = cfg_err_q;

endmodule

// File: tb/tb_entropy_src_ht_window_ctrl.sv
// Self-checking bench for entropy_src_ht_window_ctrl: directed scenarios plus random
// traffic, all compared against a symbol-counting reference model.
module tb_entropy_src_ht_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] window_size;
    logic        symbol_vld;
    logic [4:0]  test_fail;
    logic [15:0] alert_threshold;
    logic        rst_alert_cntr;
    logic        ht_done_pulse;
    logic        ht_fail_pulse;
    logic        alert_thresh_fail;
    logic [4:0]  fail_tests;
    logic [15:0] alert_cnt;
    logic [15:0] total_fail_cnt;
    logic [15:0] window_bits;
    logic        cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, in symbol-count terms
    bit         m_en_q = 0;
    bit         m_active = 0;
    bit         m_eval = 0;
    bit         m_cfg_err = 0;
    int         m_size = 0;
    int         m_bits = 0;
    logic [4:0] m_sticky = '0;
    logic [4:0] m_pend = '0;
    logic [4:0] m_fail_tests = '0;
    int         m_alert = 0;
    int         m_total = 0;

    int seen_done = 0;
    bit last_fail = 0;
    bit last_thr = 0;

    entropy_src_ht_window_ctrl #(
        .RngBusWidth(4),
        .NumTests(5),
        .CntWidth(16)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .enable_i            (enable),
        .window_size_i       (window_size),
        .symbol_vld_i        (symbol_vld),
        .test_fail_i         (test_fail),
        .alert_threshold_i   (alert_threshold),
        .rst_alert_cntr_i    (rst_alert_cntr),
        .ht_done_pulse_o     (ht_done_pulse),
        .ht_fail_pulse_o     (ht_fail_pulse),
        .alert_thresh_fail_o (alert_thresh_fail),
        .fail_tests_o        (fail_tests),
        .alert_cnt_o         (alert_cnt),
        .total_fail_cnt_o    (total_fail_cnt),
        .window_bits_o       (window_bits),
        .cfg_err_o           (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare this cycle's outputs to the model, then advance the model by one clock
    task automatic model_cycle();
        logic [4:0] e_fails;
        logic [4:0] new_f;
        bit         e_done;
        bit         e_fail;
        bit         closed;
        int         a_next;
        e_done  = m_eval && enable;
        e_fails = m_pend | test_fail;
        e_fail  = e_done && (e_fails != 5'd0);
        a_next  = m_alert + (e_fail ? 1 : 0);
        if (a_next > 65535) a_next = 65535;

        check("done", 32'(ht_done_pulse), 32'(e_done));
        if (e_done) begin
            check("fail_pulse", 32'(ht_fail_pulse), 32'(e_fail));
            check("thresh", 32'(alert_thresh_fail),
                  32'((alert_threshold != 16'd0) && (a_next >= int'(alert_threshold))));
        end
        check("window_bits", 32'(window_bits), 32'(m_bits));
        check("alert_cnt", 32'(alert_cnt), 32'(m_alert));
        check("total_fail", 32'(total_fail_cnt), 32'(m_total));
        check("fail_tests", 32'(fail_tests), 32'(m_fail_tests));
        check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));

        if (ht_done_pulse) begin
            seen_done++;
            last_fail = ht_fail_pulse;
            last_thr  = alert_thresh_fail;
        end

        if (!enable) begin
            m_active = 0; m_eval = 0; m_bits = 0; m_sticky = '0; m_pend = '0;
            m_alert = 0; m_cfg_err = 0;
        end else begin
            if (e_done) begin
                m_fail_tests = e_fails;
                if (e_fail && m_total < 65535) m_total++;
            end
            m_alert = rst_alert_cntr ? 0 : a_next;
            if (!m_active) begin
                if (!m_en_q) begin
                    m_size = int'(window_size);
                    if (m_size != 0 && (m_size % 4) == 0) m_active = 1;
                    else m_cfg_err = 1;
                end
            end else begin
                new_f  = m_eval ? 5'd0 : test_fail;
                closed = 0;
                if (symbol_vld) begin
                    m_bits += 4;
                    if (m_bits == m_size) begin
                        m_pend   = m_sticky | new_f;
                        m_sticky = '0;
                        m_bits   = 0;
                        closed   = 1;
                    end else begin
                        m_sticky |= new_f;
                    end
                end else begin
                    m_sticky |= new_f;
                end
                m_eval = closed;
            end
        end
        m_en_q = enable;
    endtask

    task automatic cycle(input bit sym, input logic [4:0] tf, input bit rac);
        symbol_vld     = sym;
        test_fail      = tf;
        rst_alert_cntr = rac;
        #4;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_syms(input int n, input int fail_at, input logic [4:0] fbits);
        for (int i = 0; i < n; i++) cycle(1'b1, (i == fail_at) ? fbits : 5'd0, 1'b0);
    endtask

    task automatic restart(input logic [15:0] size);
        enable = 1'b0;
        cycle(1'b0, 5'd0, 1'b0);
        enable      = 1'b1;
        window_size = size;
        cycle(1'b0, 5'd0, 1'b0);
    endtask

    int d0;
    int sizes[8] = '{4, 8, 12, 16, 24, 0, 6, 10};

    initial begin
        rst_n = 1'b0; enable = 1'b0; window_size = '0; symbol_vld = 1'b0;
        test_fail = '0; alert_threshold = '0; rst_alert_cntr = 1'b0;
        #12;
        check("rst_done", 32'(ht_done_pulse), 32'd0);
        check("rst_alert", 32'(alert_cnt), 32'd0);
        check("rst_total", 32'(total_fail_cnt), 32'd0);
        check("rst_bits", 32'(window_bits), 32'd0);
        check("rst_cfg", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 384-bit window, no fails
        restart(16'd384);
        d0 = seen_done;
        run_syms(96, -1, 5'd0);
        cycle(1'b0, 5'd0, 1'b0);
        check("w384_one_done", 32'(seen_done - d0), 32'd1);
        check("w384_pass", 32'(last_fail), 32'd0);
        check("w384_bits0", 32'(window_bits), 32'd0);

        // Fail on test 2 at symbol 10
        restart(16'd384);
        run_syms(96, 9, 5'b00100);
        cycle(1'b0, 5'd0, 1'b0);
        check("t2_fail", 32'(last_fail), 32'd1);
        check("t2_tests", 32'(fail_tests), 32'b00100);
        check("t2_total", 32'(total_fail_cnt), 32'd1);

        // Late fail and next-window symbol both in the Eval cycle
        run_syms(96, -1, 5'd0);
        cycle(1'b1, 5'b00001, 1'b0);
        check("late_fail", 32'(last_fail), 32'd1);
        check("late_tests", 32'(fail_tests), 32'b00001);
        check("next_bits4", 32'(window_bits), 32'd4);
        run_syms(95, -1, 5'd0);
        cycle(1'b0, 5'd0, 1'b0);
        check("next_pass", 32'(last_fail), 32'd0);

        // Alert threshold 2
        alert_threshold = 16'd2;
        restart(16'd384);
        run_syms(96, 3, 5'b01000);
        cycle(1'b0, 5'd0, 1'b0);
        check("thr_first", 32'(last_thr), 32'd0);
        run_syms(96, 50, 5'b10000);
        cycle(1'b0, 5'd0, 1'b0);
        check("thr_second", 32'(last_thr), 32'd1);
        check("alert_cnt2", 32'(alert_cnt), 32'd2);
        run_syms(96, -1, 5'd0);
        cycle(1'b0, 5'd0, 1'b1);
        check("alert_cleared", 32'(alert_cnt), 32'd0);
        alert_threshold = 16'd0;

        // Invalid sizes then a valid 8-bit window
        d0 = seen_done;
        restart(16'd0);
        run_syms(4, -1, 5'd0);
        check("cfg_zero", 32'(cfg_err), 32'd1);
        restart(16'd6);
        run_syms(6, -1, 5'd0);
        check("cfg_six", 32'(cfg_err), 32'd1);
        check("cfg_no_done", 32'(seen_done - d0), 32'd0);
        restart(16'd8);
        check("cfg_cleared", 32'(cfg_err), 32'd0);
        run_syms(2, -1, 5'd0);
        cycle(1'b0, 5'd0, 1'b0);
        check("w8_done", 32'(seen_done - d0), 32'd1);

        // Enable dropped mid-window
        d0 = seen_done;
        restart(16'd384);
        run_syms(50, 5, 5'b00010);
        enable = 1'b0;
        cycle(1'b1, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 1'b0);
        check("abort_no_done", 32'(seen_done - d0), 32'd0);
        check("abort_alert0", 32'(alert_cnt), 32'd0);
        enable = 1'b1;
        cycle(1'b0, 5'd0, 1'b0);
        run_syms(96, -1, 5'd0);
        cycle(1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 1'b0);
        check("reenable_one_done", 32'(seen_done - d0), 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            window_size = 16'(sizes[$urandom_range(0, 7)]);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 63) == 0) alert_threshold = 16'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                  ($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset mid-window
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_bits", 32'(window_bits), 32'd0);
        check("areset_total", 32'(total_fail_cnt), 32'd0);
        check("areset_tests", 32'(fail_tests), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
